ri5cy_to_ahb: RTL and testbench
===============================

Name: ri5cy_to_ahb

Overview:
AHB-Lite master bridge that converts a RI5CY core memory port (req/gnt/rvalid) into single AHB-Lite transfers. It serves as the core-side initiator in front of the AHB interconnect; AHB slaves such as on-chip RAM bridges sit at the far end. It supports pipelined back-to-back transfers with at most one AHB data phase in flight. Responses return in order.

Parameters:
AHB_ADDR_WIDTH, 32, haddr_o width; only 32 supported
AHB_DATA_WIDTH, 32, hwdata_o/hrdata_i width; only 32 supported
HPROT_VAL, 4'b0001, constant driven on hprot_o (data access)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
data_req_i  in  1  core request
data_gnt_o  out  1  request accepted (combinational)
data_we_i  in  1  1 = write
data_be_i  in  4  byte enables
data_addr_i  in  32  word-aligned core address
data_wdata_i  in  32  write data, valid until gnt
data_rvalid_o  out  1  response valid, one cycle per granted request
data_rdata_o  out  32  read data, valid with rvalid on reads
data_err_o  out  1  error flag, valid with rvalid, 0 otherwise
haddr_o  out  32  AHB address
htrans_o  out  2  IDLE 00 / NONSEQ 10 only
hwrite_o  out  1  AHB write
hsize_o  out  3  000 byte, 001 half, 010 word
hburst_o  out  3  constant 000 (SINGLE)
hprot_o  out  4  HPROT_VAL
hmastlock_o  out  1  constant 0
hwdata_o  out  32  write data (data phase)
hrdata_i  in  32  read data
hready_i  in  1  bus ready
hresp_i  in  1  error response

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Byte-enable decode (legal patterns):
  - be 1111 -> hsize 010, haddr[1:0]=00.
  - be 0011 / 1100 -> hsize 001, offset 00 / 10.
  - be 0001 / 0010 / 0100 / 1000 -> hsize 000, offset 00 / 01 / 10 / 11.
  - All other patterns are illegal.
  - haddr_o = {data_addr_i[31:2], offset}.
- Address-phase signals (haddr, hwrite, hsize) are driven combinationally from core inputs in every state. htrans_o is NONSEQ only when issuing.
- FSM states: IDLE, DATA (one AHB data phase outstanding), ERR (local error response).
- IDLE state:
  - Legal req: htrans=NONSEQ. gnt=hready_i. On gnt -> DATA.
  - Illegal req: htrans=IDLE, gnt=1, -> ERR.
  - No req: stay IDLE.
- DATA state:
  - hready_i=0, hresp_i=0: stay DATA, gnt=0. htrans=NONSEQ if a legal req is present (held by core until gnt).
  - hready_i=1, hresp_i=0: rvalid=1, err=0. If a legal req is present: NONSEQ, gnt=1, stay DATA. Otherwise -> IDLE.
  - hresp_i=1 (either error cycle): htrans forced IDLE, gnt=0.
  - hresp_i=1 with hready_i=1: rvalid=1, err=1, -> IDLE.
  - Illegal req pending: never granted in DATA; waits for IDLE.
- ERR state: rvalid=1, err=1, no bus activity, gnt=0, -> IDLE.
- Write data: data_wdata_i is registered into wdata_q on every gnt with we=1. hwdata_o=wdata_q; it holds until the next write gnt.
- data_rdata_o = hrdata_i passthrough.
- Latency: zero-wait read, gnt in cycle N, rvalid in N+1. Throughput is 1 transfer/cycle.
- Reset: state->IDLE, wdata_q=0. While rst=1: gnt=0, rvalid=0, err=0, htrans=IDLE. Reset during DATA abandons the transfer with no rvalid.
- Constant outputs: hburst=000, hmastlock=0, hprot=HPROT_VAL.

Decomposition:
- Package ri5cy_ahb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
  - HSIZE codes (BYTE/HALFWORD/WORD).
  - HBURST_SINGLE.
  - FSM state enum (IDLE/DATA/ERR).
- One combinational sub-module, ri5cy_be_decode: be[3:0] -> hsize, addr offset[1:0], legal flag.

Test Plan:
1. Read, addr 0x1000_0004, be 1111, hready=1, hrdata 0xDEADBEEF.
   -> Same-cycle gnt; haddr 0x10000004, htrans 10, hsize 010.
   -> Next cycle: rvalid=1, rdata 0xDEADBEEF, err=0.
2. Write, addr 0x20, be 0100, wdata 0x00AB0000.
   -> haddr 0x22, hsize 000, hwrite=1.
   -> Next cycle: hwdata 0x00AB0000, rvalid=1.
3. Read with hready=0 for 2 data-phase cycles, second req pending.
   -> rvalid on 3rd data cycle; second req gnt in the same cycle; haddr stable throughout.
4. Three consecutive legal reads, zero-wait.
   -> gnt on 3 consecutive cycles, rvalid on the 3 following cycles, data in order.
5. Data phase answered hresp=1/hready=0, then hresp=1/hready=1, with a pending req.
   -> htrans=00 and gnt=0 in both cycles; rvalid+err=1 in the second.
   -> Pending req gets NONSEQ+gnt in the next cycle.
6. Illegal be 0110.
   -> gnt=1, htrans stays 00, next-cycle rvalid=1, err=1.
   -> Separate case: rst asserted mid-DATA -> htrans=00, rvalid=0 until a new req.

Source files
------------

// File: rtl/ri5cy_ahb_pkg.sv
// rtl/ri5cy_ahb_pkg.sv - AHB-Lite codes and bridge state type shared by the RI5CY bridge
package ri5cy_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE     = 3'b000;
    localparam logic [2:0] HSIZE_HALFWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD     = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR  = 2'b10
    } state_e;

endpackage

// File: rtl/ri5cy_be_decode.sv
// rtl/ri5cy_be_decode.sv - byte-enable to hsize/address-offset decode with legality flag
module ri5cy_be_decode
    import ri5cy_ahb_pkg::*;
(
    input  logic [3:0] be_i,
    output logic [2:0] hsize_o,
    output logic [1:0] offset_o,
    output logic       legal_o
);

    // Only naturally aligned byte, halfword and word patterns map onto one AHB transfer
    always_comb begin
        hsize_o  = HSIZE_BYTE;
        offset_o = 2'b00;
        legal_o  = 1'b0;
        case (be_i)
            4'b1111: begin hsize_o = HSIZE_WORD;     offset_o = 2'b00; legal_o = 1'b1; end
            4'b0011: begin hsize_o = HSIZE_HALFWORD; offset_o = 2'b00; legal_o = 1'b1; end
            4'b1100: begin hsize_o = HSIZE_HALFWORD; offset_o = 2'b10; legal_o = 1'b1; end
            4'b0001: begin hsize_o = HSIZE_BYTE;     offset_o = 2'b00; legal_o = 1'b1; end
            4'b0010: begin hsize_o = HSIZE_BYTE;     offset_o = 2'b01; legal_o = 1'b1; end
            4'b0100: begin hsize_o = HSIZE_BYTE;     offset_o = 2'b10; legal_o = 1'b1; end
            4'b1000: begin hsize_o = HSIZE_BYTE;     offset_o = 2'b11; legal_o = 1'b1; end
            default: begin hsize_o = HSIZE_BYTE;     offset_o = 2'b00; legal_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/ri5cy_to_ahb.sv
// rtl/ri5cy_to_ahb.sv - RI5CY req/gnt/rvalid data port to AHB-Lite single-transfer master
module ri5cy_to_ahb
    import ri5cy_ahb_pkg::*;
#(
    parameter int         AHB_ADDR_WIDTH = 32,
    parameter int         AHB_DATA_WIDTH = 32,
    parameter logic [3:0] HPROT_VAL      = 4'b0001
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [AHB_ADDR_WIDTH-1:0] data_addr_i,
    input  logic [AHB_DATA_WIDTH-1:0] data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [AHB_DATA_WIDTH-1:0] data_rdata_o,
    output logic                      data_err_o,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic [1:0]                htrans_o,
    output logic                      hwrite_o,
    output logic [2:0]                hsize_o,
    output logic [2:0]                hburst_o,
    output logic [3:0]                hprot_o,
    output logic                      hmastlock_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    input  logic                      hready_i,
    input  logic                      hresp_i
);

    localparam logic [AHB_ADDR_WIDTH-1:0] WORD_MASK = {{(AHB_ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_e                    state_q, state_d;
    logic [AHB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]                be_offset;
    logic                      be_legal;
    logic                      legal_req;

    ri5cy_be_decode u_be_decode (
        .be_i     (data_be_i),
        .hsize_o  (hsize_o),
        .offset_o (be_offset),
        .legal_o  (be_legal)
    );

    assign legal_req    = data_req_i && be_legal;
    assign haddr_o      = (data_addr_i & WORD_MASK) | {{(AHB_ADDR_WIDTH-2){1'b0}}, be_offset};
    assign hwrite_o     = data_we_i;
    assign hburst_o     = HBURST_SINGLE;
    assign hprot_o      = HPROT_VAL;
    assign hmastlock_o  = 1'b0;
    assign hwdata_o     = wdata_q;
    assign data_rdata_o = hrdata_i;

    // Next state, handshakes and htrans; at most one data phase is outstanding at a time
    always_comb begin
        state_d       = state_q;
        wdata_d       = wdata_q;
        data_gnt_o    = 1'b0;
        data_rvalid_o = 1'b0;
        data_err_o    = 1'b0;
        htrans_o      = HTRANS_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (legal_req) begin
                    htrans_o   = HTRANS_NONSEQ;
                    data_gnt_o = hready_i;
                    if (hready_i) state_d = ST_DATA;
                end else if (data_req_i) begin
                    // Illegal byte enables are answered locally, never reaching the bus
                    data_gnt_o = 1'b1;
                    state_d    = ST_ERR;
                end
            end
            ST_DATA: begin
                if (hresp_i) begin
                    // Both error cycles suppress a new address phase
                    if (hready_i) begin
                        data_rvalid_o = 1'b1;
                        data_err_o    = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end else if (!hready_i) begin
                    if (legal_req) htrans_o = HTRANS_NONSEQ;
                end else begin
                    data_rvalid_o = 1'b1;
                    if (legal_req) begin
                        htrans_o   = HTRANS_NONSEQ;
                        data_gnt_o = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                data_rvalid_o = 1'b1;
                data_err_o    = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (data_gnt_o && data_we_i) wdata_d = data_wdata_i;
        if (rst) begin
            data_gnt_o    = 1'b0;
            data_rvalid_o = 1'b0;
            data_err_o    = 1'b0;
            htrans_o      = HTRANS_IDLE;
        end
    end

    // State and write-data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_ri5cy_to_ahb.sv
// tb/tb_ri5cy_to_ahb.sv - scoreboard bench for the RI5CY to AHB-Lite bridge
module tb_ri5cy_to_ahb;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic [31:0] haddr_o, hwdata_o, hrdata_i;
    logic [1:0]  htrans_o;
    logic        hwrite_o, hmastlock_o, hready_i, hresp_i;
    logic [2:0]  hsize_o, hburst_o;
    logic [3:0]  hprot_o;

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    ri5cy_to_ahb dut (
        .clk           (clk),
        .rst           (rst),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .haddr_o       (haddr_o),
        .htrans_o      (htrans_o),
        .hwrite_o      (hwrite_o),
        .hsize_o       (hsize_o),
        .hburst_o      (hburst_o),
        .hprot_o       (hprot_o),
        .hmastlock_o   (hmastlock_o),
        .hwdata_o      (hwdata_o),
        .hrdata_i      (hrdata_i),
        .hready_i      (hready_i),
        .hresp_i       (hresp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rdy, input logic resp, input logic [31:0] rdata);
        data_req_i   = req;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        hready_i     = rdy;
        hresp_i      = resp;
        hrdata_i     = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic is_wr, input logic [31:0] data, input logic err);
        exp_t e;
        e.is_wr = is_wr;
        e.data  = data;
        e.err   = err;
        q.push_back(e);
    endtask

    // Monitor: every rvalid consumes the oldest expected response
    always @(negedge clk) begin
        if (data_rvalid_o === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_err", {31'd0, data_err_o}, {31'd0, e.err});
                if (!e.err && !e.is_wr) chk("rsp_rdata", data_rdata_o, e.data);
                if (!e.err && e.is_wr)  chk("rsp_hwdata", hwdata_o, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
        chk("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        chk("rst_htrans", {30'd0, htrans_o}, 32'd0);
        chk("rst_hwdata", hwdata_o, 32'd0);
        chk("const_hburst", {29'd0, hburst_o}, 32'd0);
        chk("const_hprot", {28'd0, hprot_o}, 32'd1);
        chk("const_hmastlock", {31'd0, hmastlock_o}, 32'd0);

        // 1: zero-wait word read
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'hF, 32'h1000_0004, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t1_gnt", {31'd0, data_gnt_o}, 32'd1);
        chk("t1_haddr", haddr_o, 32'h1000_0004);
        chk("t1_htrans", {30'd0, htrans_o}, 32'd2);
        chk("t1_hsize", {29'd0, hsize_o}, 32'd2);
        chk("t1_hwrite", {31'd0, hwrite_o}, 32'd0);
        expect_rsp(1'b0, 32'hDEAD_BEEF, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_rvalid", {31'd0, data_rvalid_o}, 32'd1);

        // 2: byte write at lane 2
        next_cycle();
        drive(1'b1, 1'b1, 4'b0100, 32'h0000_0020, 32'h00AB_0000, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t2_gnt", {31'd0, data_gnt_o}, 32'd1);
        chk("t2_haddr", haddr_o, 32'h0000_0022);
        chk("t2_hsize", {29'd0, hsize_o}, 32'd0);
        chk("t2_hwrite", {31'd0, hwrite_o}, 32'd1);
        expect_rsp(1'b1, 32'h00AB_0000, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 4'hF, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t2_rvalid", {31'd0, data_rvalid_o}, 32'd1);

        // 3: two wait states with a second request held by the core
        next_cycle();
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t3_gnt_a", {31'd0, data_gnt_o}, 32'd1);
        expect_rsp(1'b0, 32'h1111_1111, 1'b0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            drive(1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            chk("t3_wait_gnt", {31'd0, data_gnt_o}, 32'd0);
            chk("t3_wait_rvalid", {31'd0, data_rvalid_o}, 32'd0);
            chk("t3_wait_htrans", {30'd0, htrans_o}, 32'd2);
            chk("t3_wait_haddr", haddr_o, 32'h0000_0200);
        end
        next_cycle();
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 32'h1111_1111);
        @(negedge clk);
        chk("t3_gnt_b", {31'd0, data_gnt_o}, 32'd1);
        chk("t3_rvalid_a", {31'd0, data_rvalid_o}, 32'd1);
        expect_rsp(1'b0, 32'h2222_2222, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h2222_2222);
        @(negedge clk);
        chk("t3_rvalid_b", {31'd0, data_rvalid_o}, 32'd1);

        // 4: three back-to-back zero-wait reads
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b1, 1'b0, 4'hF, 32'h0000_0300 + 32'(4 * i), 32'h0, 1'b1, 1'b0,
                  32'hA000_0000 + 32'(i - 1));
            @(negedge clk);
            chk("t4_gnt", {31'd0, data_gnt_o}, 32'd1);
            chk("t4_htrans", {30'd0, htrans_o}, 32'd2);
            expect_rsp(1'b0, 32'hA000_0000 + 32'(i), 1'b0);
        end
        next_cycle();
        drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 32'hA000_0002);
        @(negedge clk);
        chk("t4_rvalid_last", {31'd0, data_rvalid_o}, 32'd1);

        // 5: two-cycle AHB error response with a pending request
        next_cycle();
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t5_gnt_a", {31'd0, data_gnt_o}, 32'd1);
        expect_rsp(1'b0, 32'h0, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0404, 32'h0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("t5_err1_htrans", {30'd0, htrans_o}, 32'd0);
        chk("t5_err1_gnt", {31'd0, data_gnt_o}, 32'd0);
        chk("t5_err1_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0404, 32'h0, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        chk("t5_err2_htrans", {30'd0, htrans_o}, 32'd0);
        chk("t5_err2_gnt", {31'd0, data_gnt_o}, 32'd0);
        chk("t5_err2_rvalid", {31'd0, data_rvalid_o}, 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0404, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t5_retry_htrans", {30'd0, htrans_o}, 32'd2);
        chk("t5_retry_gnt", {31'd0, data_gnt_o}, 32'd1);
        expect_rsp(1'b0, 32'h5555_5555, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h5555_5555);
        @(negedge clk);

        // 6: illegal byte enables answered locally
        next_cycle();
        drive(1'b1, 1'b0, 4'b0110, 32'h0000_0500, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t6_gnt", {31'd0, data_gnt_o}, 32'd1);
        chk("t6_htrans", {30'd0, htrans_o}, 32'd0);
        expect_rsp(1'b0, 32'h0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t6_rvalid", {31'd0, data_rvalid_o}, 32'd1);
        chk("t6_err_htrans", {30'd0, htrans_o}, 32'd0);

        // Reset while a data phase is outstanding abandons it
        next_cycle();
        drive(1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t7_gnt", {31'd0, data_gnt_o}, 32'd1);
        next_cycle();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h7777_7777);
        @(negedge clk);
        chk("t7_rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        chk("t7_rst_htrans", {30'd0, htrans_o}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("t7_post_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        chk("t7_post_htrans", {30'd0, htrans_o}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t7_post2_rvalid", {31'd0, data_rvalid_o}, 32'd0);

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
